// File: rtl/fa.sv
// Full adder with both combinational and registered views of the result.
//
// Ports:
//   clk          - single clock, registers update on its rising edge
//   rst_n        - asynchronous active-low reset, clears only the registered outputs
//   x, y         - addend bits
//   Carry_in     - carry input
//   s            - combinational sum bit (x ^ y ^ Carry_in)
//   Carry_out    - combinational carry-out bit (majority of the three inputs)
//   s_q          - sum bit captured on the last rising clk edge
//   Carry_out_q  - carry-out bit captured on the last rising clk edge
module fa (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  input  logic y,
  input  logic Carry_in,
  output logic s,
  output logic Carry_out,
  output logic s_q,
  output logic Carry_out_q
);

  logic s_d;
  logic carry_out_d;

  // Purely combinational path: independent of clk and rst_n.
  always_comb begin
    s_d         = x ^ y ^ Carry_in;
    carry_out_d = (x & y) | (x & Carry_in) | (y & Carry_in);
  end

  assign s         = s_d;
  assign Carry_out = carry_out_d;

  // Asynchronous reset has priority over a coincident clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= 1'b0;
      Carry_out_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      Carry_out_q <= carry_out_d;
    end
  end

endmodule

// File: tb/tb_fa.sv
// Scoreboard bench for fa: stimulus pushes hand-computed expectations, a monitor pops and
// compares them against {Carry_out, s, Carry_out_q, s_q}.
module tb_fa;

  logic clk;
  logic rst_n;
  logic x;
  logic y;
  logic Carry_in;
  logic s;
  logic Carry_out;
  logic s_q;
  logic Carry_out_q;

  fa u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .Carry_in    (Carry_in),
    .s           (s),
    .Carry_out   (Carry_out),
    .s_q         (s_q),
    .Carry_out_q (Carry_out_q)
  );

  typedef struct {
    string      name;
    logic [3:0] exp;  // {Carry_out, s, Carry_out_q, s_q}
  } item_t;

  item_t sb[$];
  event  chk_ev;
  int    n_checks = 0;
  int    n_fails  = 0;

  // Monitor: the DUT presents its outputs whenever the stimulus signals a sample point.
  initial begin
    item_t      it;
    logic [3:0] got;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        it  = sb.pop_front();
        got = {Carry_out, s, Carry_out_q, s_q};
        n_checks++;
        if (got !== it.exp) begin
          n_fails++;
          $display("FAIL %s: got {co,s,co_q,s_q}=%b expected %b", it.name, got, it.exp);
        end
      end
    end
  end

  task automatic expect_out(input string name, input logic [3:0] exp);
    item_t it;
    #1;
    it.name = name;
    it.exp  = exp;
    sb.push_back(it);
    -> chk_ev;
    #1;
  endtask

  task automatic set_in(input logic a, input logic b, input logic c);
    x        = a;
    y        = b;
    Carry_in = c;
  endtask

  // One full clock cycle; ends with clk low, away from the active edge.
  task automatic pulse();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  logic [1:0] tt_exp [8];

  initial begin
    tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    clk   = 1'b0;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);

    expect_out("reset_state", 4'b0000);

    // Truth table, no clock running, reset held so registers stay 0.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      set_in(v[0], v[1], v[2]);
      expect_out($sformatf("tt_%0d", i), {tt_exp[i], 2'b00});
    end

    set_in(1'b1, 1'b1, 1'b1);
    expect_out("comb_during_reset", 4'b1100);

    rst_n = 1'b1;
    expect_out("release_no_edge", 4'b1100);

    // One-edge latency, mid-cycle changes ignored until the next edge.
    set_in(1'b1, 1'b0, 1'b1);
    pulse();
    expect_out("reg_101", 4'b1010);
    set_in(1'b0, 1'b0, 1'b0);
    expect_out("midcycle_hold", 4'b0010);
    pulse();
    expect_out("reg_000", 4'b0000);

    // Registered value for every input combination.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      set_in(v[0], v[1], v[2]);
      pulse();
      expect_out($sformatf("reg_tt_%0d", i), {tt_exp[i], tt_exp[i]});
    end

    // Asynchronous reset between edges.
    set_in(1'b1, 1'b1, 1'b1);
    pulse();
    expect_out("reg_111", 4'b1111);
    #2 rst_n = 1'b0;
    expect_out("async_reset", 4'b1100);

    // Release with 1,1,0: no update until the first edge.
    set_in(1'b1, 1'b1, 1'b0);
    expect_out("reset_low_110", 4'b1000);
    rst_n = 1'b1;
    expect_out("released_110", 4'b1000);
    pulse();
    expect_out("first_edge_110", 4'b1010);

    // Reset coincident with a rising edge must win.
    set_in(1'b1, 1'b1, 1'b1);
    #5;
    rst_n = 1'b0;
    clk   = 1'b1;
    expect_out("reset_wins_edge", 4'b1100);
    #3 clk = 1'b0;
    expect_out("reset_hold", 4'b1100);
    rst_n = 1'b1;
    pulse();
    expect_out("post_reset_111", 4'b1111);

    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
